// File: rtl/dff_arb_pkg.sv
// Shared types and defaults for the falling-edge register write arbiter.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/dff_reg_en.sv
// WIDTH-bit falling-edge register with asynchronous active-low clear and load enable.
module dff_reg_en #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter that owns a shared falling-edge register and loads it
// on behalf of one requester at a time, returning a one-cycle acknowledge.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]          q,
    output logic [NREQ-1:0]           ack,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output arb_state_t                dbg_state
);

    localparam int           IDW    = $clog2(NREQ);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    // Handshake: a requester holds req[i] high until it sees ack[i] for one
    // cycle, then drops req[i] in that same cycle; a req still high when the
    // FSM is next in IDLE is treated as a fresh request.

    arb_state_t       r_state;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_gnt_id;
    logic             r_busy;
    logic [NREQ-1:0]  r_ack;

    logic [IDW-1:0]     w_start;
    logic [2*NREQ-1:0]  w_dbl;
    logic [NREQ-1:0]    w_rot;
    logic [IDW-1:0]     w_off;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_winner;
    logic [NREQ-1:0]    w_gnt_onehot;
    logic               w_req_gnt;
    logic               w_load;
    logic [WIDTH-1:0]   w_wdata_sel;

    // Rotate requests so the slot after the last winner sits at bit 0, then
    // take the lowest set bit and rotate the offset back into an index.
    always_comb begin
        w_start = (r_last == IDW'(NREQ-1)) ? '0 : r_last + IDW'(1);
        w_dbl   = {req, req} >> w_start;
        w_rot   = w_dbl[NREQ-1:0];
        w_off   = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
        end
        w_winner = w_sum[IDW-1:0];
    end

    always_comb begin
        w_gnt_onehot = NREQ'(1) << r_gnt_id;
        w_req_gnt    = |(req & w_gnt_onehot);
        w_load       = (r_state == GRANT) && w_req_gnt;
        w_wdata_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt_id == IDW'(i)) begin
                w_wdata_sel = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= IDW'(NREQ-1);
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ack    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt_id <= w_winner;
                        r_busy   <= 1'b1;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_req_gnt) begin
                        r_ack   <= w_gnt_onehot;
                        r_last  <= r_gnt_id;
                        r_state <= DONE;
                    end else begin
                        // Withdrawn request: abort without advancing the pointer.
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dff_reg_en #(
        .WIDTH (WIDTH)
    ) u_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_load),
        .i_d     (w_wdata_sel),
        .o_q     (q)
    );

    assign ack       = r_ack;
    assign gnt_id    = r_gnt_id;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter with a write scoreboard checked on every ack.
module tb_dff_write_arbiter;
  import dff_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int SBW   = IDW + WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [WIDTH-1:0]      q;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;
  arb_state_t            dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int prev_ack_cyc;
  logic [SBW-1:0] exp_q[$];

  dff_write_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .q         (q),
    .ack       (ack),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic reset_dut();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
  endtask

  // drivers
  task automatic set_slice(input int i, input logic [WIDTH-1:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_write(input int id, input logic [WIDTH-1:0] d);
    exp_q.push_back({IDW'(id), d});
  endtask

  // scoreboard: every ack must match the oldest expected write
  task automatic monitor();
    logic [SBW-1:0] e;
    int id;
    int hot;
    if (ack != '0) begin
      hot = 0;
      id  = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          hot++;
          id = i;
        end
      end
      chk("ack_onehot", hot, 1);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_ack", {28'd0, ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id", id, {30'd0, e[SBW-1:WIDTH]});
        chk("sb_data", {24'd0, q}, {24'd0, e[WIDTH-1:0]});
      end
    end
  endtask

  // one falling (active) edge, then sample on the following rising edge
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    cyc++;
    monitor();
  endtask

  initial begin
    rst_n = 1'b1;
    req   = '0;
    wdata = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    chk("rst_q", q, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;

    // single request from requester 1
    set_slice(1, 8'hA5);
    req = 4'b0010;
    expect_write(1, 8'hA5);
    step();
    chk("single_e0_gnt", gnt_id, 1);
    chk("single_e0_busy", busy, 1);
    chk("single_e0_ack", ack, 0);
    step();
    chk("single_e1_ack", ack, 4'b0010);
    chk("single_e1_q", q, 8'hA5);
    req = '0;
    step();
    chk("single_e2_ack", ack, 0);
    chk("single_e2_busy", busy, 0);
    chk("single_e2_state", dbg_state, IDLE);

    // all four requesting continuously from a fresh pointer
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_slice(i, 8'h10 + 8'(i));
    req = 4'b1111;
    prev_ack_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      int id;
      id = k % NREQ;
      expect_write(id, 8'h10 + 8'(id));
      step();
      chk("rr_gnt", gnt_id, id);
      step();
      chk("rr_ack", ack, 32'(1) << id);
      chk("rr_q", q, 8'h10 + id);
      if (k > 0) chk("rr_ack_spacing", cyc - prev_ack_cyc, 3);
      prev_ack_cyc = cyc;
      req[id] = 1'b0;
      step();
      chk("rr_ack_low", ack, 0);
      req[id] = 1'b1;
    end
    req = '0;
    step();

    // pointer wrap: after requester 3 writes, 0 beats 3
    req = 4'b1000;
    expect_write(3, 8'h13);
    step();
    chk("wrap_pre_gnt", gnt_id, 3);
    step();
    req = '0;
    step();
    req = 4'b1001;
    expect_write(0, 8'h10);
    step();
    chk("wrap_gnt", gnt_id, 0);
    step();
    req = '0;
    step();

    // withdrawal leaves the pointer untouched
    req = 4'b0010;
    expect_write(1, 8'h11);
    step();
    step();
    req = '0;
    step();
    req = 4'b0100;
    step();
    chk("wd_gnt", gnt_id, 2);
    req = '0;
    step();
    chk("wd_ack", ack, 0);
    chk("wd_q", q, 8'h11);
    chk("wd_busy", busy, 0);
    chk("wd_state", dbg_state, IDLE);
    req = 4'b0110;
    expect_write(2, 8'h12);
    step();
    chk("wd_regnt", gnt_id, 2);
    step();
    req = '0;
    step();

    // wdata sampled only on the write edge
    set_slice(0, 8'h11);
    req = 4'b0001;
    expect_write(0, 8'h22);
    step();
    set_slice(0, 8'h22);
    step();
    chk("stab_q", q, 8'h22);
    req = '0;
    step();
    set_slice(0, 8'h33);
    step();
    set_slice(0, 8'h44);
    step();
    chk("stab_hold_q", q, 8'h22);

    // async reset while in GRANT
    req = 4'b0001;
    step();
    chk("ar_pre_state", dbg_state, GRANT);
    rst_n = 1'b0;
    #1;
    chk("ar_q", q, 0);
    chk("ar_ack", ack, 0);
    chk("ar_busy", busy, 0);
    chk("ar_gnt", gnt_id, 0);
    chk("ar_state", dbg_state, IDLE);
    req = '0;
    @(posedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    expect_write(0, 8'h44);
    step();
    chk("ar_prio_gnt", gnt_id, 0);
    step();
    req = '0;
    step();

    // async reset while ack is high
    req = 4'b0010;
    expect_write(1, 8'h11);
    step();
    step();
    chk("ar_ack_pre", ack, 4'b0010);
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("ar_ack_drop", ack, 0);
    chk("ar_ack_q", q, 0);
    chk("ar_ack_busy", busy, 0);
    @(posedge clk);
    rst_n = 1'b1;
    step();

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit register built from the team's falling-edge D flip-flops. Up to NREQ requesters compete for write access. The block grants one requester at a time, performs the load, and returns a one-cycle acknowledge. It sits between requester logic and the shared register, which it owns and exposes as `q`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: register data width, 1..32.
- `clk` input 1: clock; all state updates on the falling edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `req` input NREQ: per-requester write request; level-held until acknowledged.
- `wdata` input NREQ*WIDTH: flattened write data; requester i uses `wdata[i*WIDTH +: WIDTH]`.
- `q` output WIDTH: shared register contents.
- `ack` output NREQ: one-hot, one-cycle write acknowledge.
- `gnt_id` output $clog2(NREQ): index of the current or last granted requester.
- `busy` output 1: high while in GRANT or DONE.

## Operation
- Reset value of every output and state element while `rst_n`=0:
  - `q`=0, `ack`=0, `gnt_id`=0, `busy`=0.
  - state=IDLE, round-robin pointer `last`=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, GRANT, DONE.
- IDLE
  - If `req`≠0: winner is the first set bit searching upward from `last+1`, with modulo-NREQ wrap.
  - On that edge: `gnt_id`←winner, `busy`←1, go to GRANT.
  - If `req`=0: stay in IDLE.
- GRANT
  - If `req[gnt_id]`=1: `q`←winner's `wdata` slice, `ack[gnt_id]`←1, `last`←`gnt_id`, go to DONE.
  - If `req[gnt_id]`=0 (withdrawn): abort. No write, no ack, `last` unchanged, `busy`←0, go to IDLE.
- DONE
  - `ack`←0, `busy`←0, go to IDLE.
- Requester rule: deassert `req` in the cycle `ack` is high. A `req` still high when IDLE next samples it counts as a new request.
- Arbitration is decided only in IDLE. Requests arriving in GRANT or DONE wait for the next IDLE.
- `q` changes only on a GRANT→DONE edge. Otherwise it holds its value.
- `wdata` is sampled only on the write edge. Changes at any other time are ignored.

## Timing
- Edge numbering: all edges below are falling edges of `clk`. E0 is the first edge that samples `req`≠0 in IDLE.
- E0: `gnt_id` and `busy` update.
- E1: `q` and `ack` update. Request-to-ack latency is 2 edges.
- E2: `ack` returns to 0 and `busy` to 0.
- E3: earliest next grant decision. Peak throughput is one write per 3 cycles.
- Simultaneous requests: one winner per arbitration. Any requester with a held request is granted within NREQ arbitrations.
- Reset mid-operation (GRANT or DONE): outputs clear immediately, without waiting for a clock edge.
  - An in-flight write that has not reached its write edge is lost.
  - An `ack` already high drops to 0.

## Structure
- Shared package `dff_arb_pkg`:
  - state enum: IDLE=2'd0, GRANT=2'd1, DONE=2'd2.
  - default constants for NREQ and WIDTH.
- One sub-module, `dff_reg_en`: WIDTH-bit falling-edge register with async active-low clear and load enable. It holds `q`.
- Arbitration logic and FSM live in the top module.

## Test plan
- Reset then single request: `req`=4'b0010, slice 1=8'hA5.
  - `gnt_id`=1 at E0.
  - `q`=8'hA5 and `ack`=4'b0010 at E1.
  - `ack`=0 and `busy`=0 at E2.
- All four requesting continuously, each re-requesting right after its ack, with slice i=8'h10+i.
  - Grant order 0,1,2,3,0.
  - `q` sequence 10,11,12,13,10.
  - One ack every 3 cycles.
- Pointer wrap: after a write by requester 3, `req`=4'b1001.
  - Requester 0 is granted next, not 3.
- Withdrawal: requester 2 granted at E0, `req[2]` dropped before E1.
  - No ack, `q` unchanged, state back to IDLE.
  - A later `req`=4'b0110 grants requester 2, because `last` was not advanced.
- Data stability: `wdata` slice 0 changes 8'h11→8'h22 between E0 and E1.
  - `q`=8'h22.
  - Later changes to `wdata` with no request leave `q` at 8'h22.
- Async reset during GRANT: `rst_n` pulled low between edges.
  - `q`, `ack`, `busy` and `gnt_id` go to 0 before the next clock edge.
  - After release, requester 0 has first priority.
